// File: rtl/keccak_squeeze_serializer.sv
// keccak_squeeze_serializer
//
// Output stage of the Keccak core. Captures the rate portion of the
// permutation state and streams the digest out as 32-bit words. For SHAKE
// outputs longer than one rate block, it requests another permutation and
// recaptures the state when that permutation completes.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   cmode, d      - mode and SHAKE output length in bits, sampled on start
//   start         - begin a digest; state_in holds the post-absorb state
//   state_in      - Keccak state, lane 0 in bits [63:0]
//   perm_done     - requested permutation finished; state_in holds new state
//   perm_req      - one-cycle request for one more permutation
//   wr_en         - downstream accept; a word moves when ready && wr_en
//   dt_o_hash     - current output word, digest byte order when printed %h
//   ready         - dt_o_hash is valid
//   finish_hash   - digest complete, held until the next accepted start
module keccak_squeeze_serializer #(
    parameter int unsigned STATE_W = 1600,
    parameter int unsigned WORD_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         cmode,
    input  logic [10:0]        d,
    input  logic               start,
    input  logic [STATE_W-1:0] state_in,
    input  logic               perm_done,
    output logic               perm_req,
    input  logic               wr_en,
    output logic [WORD_W-1:0]  dt_o_hash,
    output logic               ready,
    output logic               finish_hash
);

    // Largest rate of any supported mode (SHAKE128: 42 words).
    localparam int unsigned BUF_W = 1344;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StWaitPerm,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   blk_q, blk_d;
    logic [5:0]         total_q, total_d;
    logic [5:0]         rate_q, rate_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [5:0]         idx_q, idx_d;
    logic               perm_req_q, perm_req_d;
    logic               ready_q, ready_d;
    logic               finish_q, finish_d;
    logic [WORD_W-1:0]  dout_q, dout_d;

    // Capacity lanes and the sub-word part of d never affect the output.
    logic unused_bits;
    assign unused_bits = ^{state_in[STATE_W-1:BUF_W], d[4:0]};

    function automatic logic [5:0] total_words(input logic [2:0] m, input logic [10:0] len);
        logic [5:0] n;
        case (m)
            3'd0:    n = 6'd7;
            3'd1:    n = 6'd8;
            3'd2:    n = 6'd12;
            3'd3:    n = 6'd16;
            3'd4,
            3'd5:    n = len[10:5];
            default: n = 6'd0;
        endcase
        return n;
    endfunction

    function automatic logic [5:0] rate_words(input logic [2:0] m);
        logic [5:0] n;
        case (m)
            3'd0:    n = 6'd36;
            3'd1:    n = 6'd34;
            3'd2:    n = 6'd26;
            3'd3:    n = 6'd18;
            3'd4:    n = 6'd42;
            3'd5:    n = 6'd34;
            default: n = 6'd42;
        endcase
        return n;
    endfunction

    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        total_d    = total_q;
        rate_d     = rate_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        perm_req_d = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    blk_d   = state_in[BUF_W-1:0];
                    total_d = total_words(cmode, d);
                    rate_d  = rate_words(cmode);
                    cnt_d   = 6'd0;
                    idx_d   = 6'd0;
                    state_d = (total_d == 6'd0) ? StDone : StEmit;
                end
            end
            StEmit: begin
                if (wr_en) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_d == total_q) begin
                        state_d = StDone;
                    end else if (idx_q == rate_q - 6'd1) begin
                        state_d    = StWaitPerm;
                        perm_req_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        // The current word always sits in the low 32 bits.
                        blk_d = {32'd0, blk_q[BUF_W-1:32]};
                    end
                end
            end
            StWaitPerm: begin
                if (perm_done) begin
                    blk_d   = state_in[BUF_W-1:0];
                    idx_d   = 6'd0;
                    state_d = StEmit;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from next-state values so they line up with state_q.
        ready_d  = (state_d == StEmit);
        finish_d = (state_d == StDone);
        // Byte 4k of the block lands in the top byte of the word.
        dout_d   = ready_d ? {blk_d[7:0], blk_d[15:8], blk_d[23:16], blk_d[31:24]} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            blk_q      <= '0;
            total_q    <= 6'd0;
            rate_q     <= 6'd0;
            cnt_q      <= 6'd0;
            idx_q      <= 6'd0;
            perm_req_q <= 1'b0;
            ready_q    <= 1'b0;
            finish_q   <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            total_q    <= total_d;
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            perm_req_q <= perm_req_d;
            ready_q    <= ready_d;
            finish_q   <= finish_d;
            dout_q     <= dout_d;
        end
    end

    assign perm_req    = perm_req_q;
    assign ready       = ready_q;
    assign finish_hash = finish_q;
    assign dt_o_hash   = dout_q;

endmodule

// File: tb/tb_keccak_squeeze_serializer.sv
// Testbench for keccak_squeeze_serializer: directed scenarios plus randomized
// digests, checked against a word-stream model built from the mode table.
module tb_keccak_squeeze_serializer;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    cmode;
    logic [10:0]   d;
    logic          start;
    logic [1599:0] state_in;
    logic          perm_done;
    logic          perm_req;
    logic          wr_en;
    logic [31:0]   dt_o_hash;
    logic          ready;
    logic          finish_hash;

    int tests_run    = 0;
    int tests_failed = 0;

    keccak_squeeze_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .cmode      (cmode),
        .d          (d),
        .start      (start),
        .state_in   (state_in),
        .perm_done  (perm_done),
        .perm_req   (perm_req),
        .wr_en      (wr_en),
        .dt_o_hash  (dt_o_hash),
        .ready      (ready),
        .finish_hash(finish_hash)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_total(input logic [2:0] cm, input logic [10:0] dd);
        case (cm)
            3'd0: return 7;
            3'd1: return 8;
            3'd2: return 12;
            3'd3: return 16;
            3'd4, 3'd5: return int'(dd) / 32;
            default: return 0;
        endcase
    endfunction

    function automatic int m_rate(input logic [2:0] cm);
        case (cm)
            3'd0: return 36;
            3'd1: return 34;
            3'd2: return 26;
            3'd3: return 18;
            3'd4: return 42;
            3'd5: return 34;
            default: return 1;
        endcase
    endfunction

    // Word k of a block: bytes 4k..4k+3, first byte most significant.
    function automatic logic [31:0] m_word(input logic [1599:0] st, input int k);
        return {st[32*k +: 8], st[32*k+8 +: 8], st[32*k+16 +: 8], st[32*k+24 +: 8]};
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic do_reset();
        start = 1'b0; perm_done = 1'b0; wr_en = 1'b0; cmode = 3'd0; d = 11'd0;
        state_in = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one digest from an accepted start to finish_hash.
    // wr_mode: 0 = always accept, 1 = accept on odd cycles, 2 = random.
    // noise: inject ignored start / perm_done pulses while the digest runs.
    task automatic run_digest(input logic [2:0] cm, input logic [10:0] dd, input int wr_mode,
                              input int perm_delay, input bit noise,
                              input logic [1599:0] first_state,
                              output int n_xfer, output int fin_cycle,
                              output logic [31:0] first_word, output logic [31:0] last_word);
        logic [1599:0] blocks[$];
        int total, rate, n_perm, exp_perm, last_xfer, done_at, perm_at, cyc;
        bit wr, any_ready, hold_prev;
        logic [31:0] prev_dt, exp_w;

        total    = m_total(cm, dd);
        rate     = m_rate(cm);
        exp_perm = (total == 0) ? 0 : (total - 1) / rate;
        blocks.delete();
        blocks.push_back(first_state);
        n_xfer = 0; n_perm = 0; fin_cycle = -1; last_xfer = 0; done_at = -1; perm_at = -1;
        any_ready = 1'b0; hold_prev = 1'b0; prev_dt = '0; first_word = '0; last_word = '0;

        cmode = cm; d = dd; state_in = first_state; start = 1'b1; perm_done = 1'b0;
        wr_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cmode = 3'($urandom);
        d     = 11'($urandom);

        cyc = 1;
        while (cyc < 3000 && fin_cycle < 0) begin
            tests_run++;
            if (ready === 1'b1 && finish_hash === 1'b1) begin
                tests_failed++;
                $display("FAIL ready_finish_excl cyc %0d: both high", cyc);
            end
            if (ready === 1'b1) any_ready = 1'b1;
            if (cyc == 1 && total > 0) begin
                tests_run++;
                if (ready !== 1'b1 || finish_hash !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL first_cycle: ready %b finish %b, required 1 0",
                             ready, finish_hash);
                end
            end
            if (hold_prev) begin
                tests_run++;
                if (ready !== 1'b1 || dt_o_hash !== prev_dt) begin
                    tests_failed++;
                    $display("FAIL hold cyc %0d: ready %b word %h, required 1 %h",
                             cyc, ready, dt_o_hash, prev_dt);
                end
            end
            if (done_at > 0 && cyc == done_at + 1) begin
                tests_run++;
                if (ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL perm_resume cyc %0d: ready %b, required 1", cyc, ready);
                end
            end
            if (perm_req === 1'b1) begin
                n_perm++;
                tests_run++;
                if (ready !== 1'b0 || cyc != last_xfer + 1) begin
                    tests_failed++;
                    $display("FAIL perm_timing: cyc %0d ready %b, required cyc %0d ready 0",
                             cyc, ready, last_xfer + 1);
                end
                blocks.push_back(rand_state());
                perm_at = cyc + perm_delay;
            end

            if (finish_hash === 1'b1) begin
                fin_cycle = cyc;
            end else begin
                if (wr_mode == 0)      wr = 1'b1;
                else if (wr_mode == 1) wr = (cyc % 2 == 1);
                else                   wr = ($urandom_range(9) < 7);
                wr_en = wr;
                if (ready === 1'b1 && wr) begin
                    tests_run++;
                    if (n_xfer >= total) begin
                        tests_failed++;
                        $display("FAIL extra_word: transfer %0d beyond total %0d", n_xfer, total);
                    end else begin
                        exp_w = m_word(blocks[n_xfer / rate], n_xfer % rate);
                        if (dt_o_hash !== exp_w) begin
                            tests_failed++;
                            $display("FAIL word[%0d]: got %h, required %h",
                                     n_xfer, dt_o_hash, exp_w);
                        end
                    end
                    if (n_xfer == 0) first_word = dt_o_hash;
                    last_word = dt_o_hash;
                    n_xfer++;
                    last_xfer = cyc;
                end
                hold_prev = (ready === 1'b1) && !wr;
                prev_dt   = dt_o_hash;

                if (cyc == perm_at) begin
                    perm_done = 1'b1;
                    state_in  = blocks[blocks.size() - 1];
                    done_at   = cyc;
                end else begin
                    perm_done = noise && (perm_at < cyc) && ($urandom_range(7) == 0);
                    state_in  = rand_state();
                end
                start = noise && (cyc == 3 || $urandom_range(7) == 0);
                if (start) cmode = 3'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0; perm_done = 1'b0; wr_en = 1'b0;

        tests_run++;
        if (fin_cycle < 0) begin
            tests_failed++;
            $display("FAIL timeout: finish_hash not seen (mode %0d, %0d words)", cm, n_xfer);
        end
        tests_run++;
        if (n_xfer != total) begin
            tests_failed++;
            $display("FAIL word_count mode %0d: got %0d, required %0d", cm, n_xfer, total);
        end
        tests_run++;
        if (n_perm != exp_perm) begin
            tests_failed++;
            $display("FAIL perm_count mode %0d: got %0d, required %0d", cm, n_perm, exp_perm);
        end
        tests_run++;
        if (total == 0) begin
            if (fin_cycle != 1 || any_ready) begin
                tests_failed++;
                $display("FAIL zero_words: finish cyc %0d ready_seen %b, required 1 0",
                         fin_cycle, any_ready);
            end
        end else if (fin_cycle != last_xfer + 1) begin
            tests_failed++;
            $display("FAIL finish_timing: cyc %0d, required %0d", fin_cycle, last_xfer + 1);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        start = 1'b0; perm_done = 1'b0; wr_en = 1'b0; cmode = 3'd0; d = 11'd0;
        state_in = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({ready, finish_hash, perm_req, dt_o_hash} !== 35'd0) begin
            tests_failed++;
            $display("FAIL reset_values: ready %b finish %b perm_req %b word %h, required 0",
                     ready, finish_hash, perm_req, dt_o_hash);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({ready, finish_hash, perm_req} !== 3'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: ready %b finish %b perm_req %b, required 0",
                     ready, finish_hash, perm_req);
        end
    endtask

    task automatic test_sha3_256_empty();
        logic [255:0]  dig;
        logic [1599:0] st;
        int n, fin;
        logic [31:0] fw, lw;
        dig = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
        st  = rand_state();
        for (int j = 0; j < 32; j++) st[8*j +: 8] = dig[255-8*j -: 8];
        run_digest(3'd1, 11'd0, 0, 0, 1'b0, st, n, fin, fw, lw);
        tests_run++;
        if (fw !== 32'ha7ffc6f8) begin
            tests_failed++;
            $display("FAIL sha256_first_word: got %h, required a7ffc6f8", fw);
        end
        tests_run++;
        if (lw !== 32'h80f8434a) begin
            tests_failed++;
            $display("FAIL sha256_last_word: got %h, required 80f8434a", lw);
        end
        tests_run++;
        if (fin != 9 || n != 8) begin
            tests_failed++;
            $display("FAIL sha256_timing: finish cyc %0d words %0d, required 9 8", fin, n);
        end
    endtask

    task automatic test_sha3_512_toggle();
        int n, fin;
        logic [31:0] fw, lw;
        run_digest(3'd3, 11'($urandom), 1, 0, 1'b0, rand_state(), n, fin, fw, lw);
        tests_run++;
        if (n != 16 || fin != 32) begin
            tests_failed++;
            $display("FAIL sha512_toggle: words %0d finish cyc %0d, required 16 32", n, fin);
        end
    endtask

    task automatic test_shake128_long();
        int n, fin;
        logic [31:0] fw, lw;
        run_digest(3'd4, 11'd2016, 0, 24, 1'b0, rand_state(), n, fin, fw, lw);
        tests_run++;
        if (n != 63 || fin != 89) begin
            tests_failed++;
            $display("FAIL shake128_long: words %0d finish cyc %0d, required 63 89", n, fin);
        end
    endtask

    task automatic test_zero_words();
        int n, fin;
        logic [31:0] fw, lw;
        run_digest(3'd5, 11'd20, 0, 0, 1'b0, rand_state(), n, fin, fw, lw);
        run_digest(3'd6, 11'($urandom), 0, 0, 1'b0, rand_state(), n, fin, fw, lw);
        run_digest(3'd7, 11'd2047, 0, 0, 1'b0, rand_state(), n, fin, fw, lw);
        tests_run++;
        if (perm_req !== 1'b0 || ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_words_idle: perm_req %b ready %b, required 0 0", perm_req, ready);
        end
    endtask

    task automatic test_restart_done();
        int n, fin;
        logic [31:0] fw, lw;
        // DUT sits in DONE from the previous scenario; spurious starts are injected mid-EMIT.
        run_digest(3'd0, 11'($urandom), 0, 0, 1'b1, rand_state(), n, fin, fw, lw);
        tests_run++;
        if (n != 7) begin
            tests_failed++;
            $display("FAIL restart_count: got %0d, required 7", n);
        end
    endtask

    task automatic test_reset_mid();
        logic [1599:0] st, st2;
        st = rand_state();
        cmode = 3'd2; d = 11'd0; state_in = st; start = 1'b1; wr_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        tests_run++;
        if (ready !== 1'b1 || dt_o_hash !== m_word(st, 5)) begin
            tests_failed++;
            $display("FAIL mid_word5: ready %b word %h, required 1 %h",
                     ready, dt_o_hash, m_word(st, 5));
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({ready, finish_hash, perm_req, dt_o_hash} !== 35'd0) begin
            tests_failed++;
            $display("FAIL async_reset: ready %b finish %b perm_req %b word %h, required 0",
                     ready, finish_hash, perm_req, dt_o_hash);
        end
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        perm_done = 1'b1; state_in = rand_state();
        @(posedge clk); #1;
        perm_done = 1'b0;
        tests_run++;
        if ({ready, finish_hash, perm_req} !== 3'd0) begin
            tests_failed++;
            $display("FAIL perm_done_after_reset: ready %b finish %b perm_req %b, required 0",
                     ready, finish_hash, perm_req);
        end
        st2 = rand_state();
        cmode = 3'd1; state_in = st2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (ready !== 1'b1 || dt_o_hash !== m_word(st2, 0)) begin
            tests_failed++;
            $display("FAIL start_after_reset: ready %b word %h, required 1 %h",
                     ready, dt_o_hash, m_word(st2, 0));
        end
        do_reset();
    endtask

    task automatic test_random();
        int n, fin;
        logic [31:0] fw, lw;
        logic [2:0] cm;
        for (int i = 0; i < 10; i++) begin
            cm = 3'($urandom_range(7));
            run_digest(cm, 11'($urandom), 2, $urandom_range(30, 1), 1'b1, rand_state(),
                       n, fin, fw, lw);
        end
    endtask

    initial begin
        test_reset();
        test_sha3_256_empty();
        test_sha3_512_toggle();
        test_shake128_long();
        test_zero_words();
        test_restart_done();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
